// File: rtl/alu64_seq_pkg.sv
// Shared types for the 64-bit ALU operation sequencer: opcodes, FSM states
// and the ALU control record.
package alu64_seq_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_NOR  = 3'b100,
    OP_NAND = 3'b101,
    OP_MUL  = 3'b110,
    OP_RSVD = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  localparam logic [1:0] ALU_OP_AND = 2'b00;
  localparam logic [1:0] ALU_OP_OR  = 2'b01;
  localparam logic [1:0] ALU_OP_ADD = 2'b10;

  typedef struct packed {
    logic       ainv;
    logic       binv;
    logic       cin;
    logic [1:0] op;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_CTRL_IDLE = '{ainv: 1'b0, binv: 1'b0, cin: 1'b0, op: ALU_OP_AND};
  localparam alu_ctrl_t ALU_CTRL_ADD  = '{ainv: 1'b0, binv: 1'b0, cin: 1'b0, op: ALU_OP_ADD};

  // Only ADD and SUB report the adder carry-out.
  function automatic logic uses_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu64_op_decode.sv
// Combinational opcode-to-ALU-control mapping with an illegal-opcode flag.
module alu64_op_decode
  import alu64_seq_pkg::*;
(
  input  logic [2:0] op,
  output alu_ctrl_t  ctrl,
  output logic       illegal
);

  // Map each opcode onto the invert/carry/operation lines of the ALU
  always_comb begin
    ctrl    = ALU_CTRL_IDLE;
    illegal = 1'b0;
    case (op)
      OP_AND:  ctrl = '{ainv: 1'b0, binv: 1'b0, cin: 1'b0, op: ALU_OP_AND};
      OP_OR:   ctrl = '{ainv: 1'b0, binv: 1'b0, cin: 1'b0, op: ALU_OP_OR};
      OP_ADD:  ctrl = ALU_CTRL_ADD;
      OP_SUB:  ctrl = '{ainv: 1'b0, binv: 1'b1, cin: 1'b1, op: ALU_OP_ADD};
      OP_NOR:  ctrl = '{ainv: 1'b1, binv: 1'b1, cin: 1'b0, op: ALU_OP_AND};
      OP_NAND: ctrl = '{ainv: 1'b1, binv: 1'b1, cin: 1'b0, op: ALU_OP_OR};
      OP_MUL:  ctrl = ALU_CTRL_ADD;
      default: begin
        ctrl    = ALU_CTRL_IDLE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu64_op_sequencer.sv
// Command-driven controller for an external 64-bit AND/OR/ADD ALU, including
// a 64-iteration shift-add unsigned multiply built on the ALU's ADD path.
module alu64_op_sequencer
  import alu64_seq_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int MUL_ITERS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ainv,
  output logic             alu_binv,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout
);

  localparam int CNT_W = $clog2(MUL_ITERS + 1);

  state_e             state_r;
  logic               carry_en_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CNT_W-1:0]   cnt_r;

  alu_ctrl_t          dec_ctrl_s;
  logic               dec_illegal_s;
  logic [WIDTH-1:0]   acc_nxt_s;
  logic [WIDTH-1:0]   mcand_nxt_s;

  alu64_op_decode u_decode (
    .op      (cmd_op),
    .ctrl    (dec_ctrl_s),
    .illegal (dec_illegal_s)
  );

  // Shift-add step: accumulate the ALU sum only when the multiplier LSB is set
  always_comb begin
    acc_nxt_s   = acc_r;
    mcand_nxt_s = mcand_r << 1;
    if (mplier_r[0]) begin
      acc_nxt_s = alu_result;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Controller FSM with registered ALU drive and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      carry_en_r <= 1'b0;
      acc_r      <= '0;
      mcand_r    <= '0;
      mplier_r   <= '0;
      cnt_r      <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ainv   <= 1'b0;
      alu_binv   <= 1'b0;
      alu_cin    <= 1'b0;
      alu_op     <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            carry_en_r <= uses_carry(cmd_op);
            if (dec_illegal_s) begin
              state_r   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_carry <= 1'b0;
              rsp_zero  <= 1'b1;
            end else if (cmd_op == OP_MUL) begin
              state_r  <= ST_MUL;
              acc_r    <= '0;
              mcand_r  <= cmd_a;
              mplier_r <= cmd_b;
              cnt_r    <= '0;
              alu_a    <= '0;
              alu_b    <= cmd_a;
              alu_ainv <= ALU_CTRL_ADD.ainv;
              alu_binv <= ALU_CTRL_ADD.binv;
              alu_cin  <= ALU_CTRL_ADD.cin;
              alu_op   <= ALU_CTRL_ADD.op;
            end else begin
              state_r  <= ST_EXEC;
              alu_a    <= cmd_a;
              alu_b    <= cmd_b;
              alu_ainv <= dec_ctrl_s.ainv;
              alu_binv <= dec_ctrl_s.binv;
              alu_cin  <= dec_ctrl_s.cin;
              alu_op   <= dec_ctrl_s.op;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          state_r   <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= alu_result;
          rsp_zero  <= (alu_result == '0);
          rsp_carry <= carry_en_r ? alu_cout : 1'b0;
          alu_a     <= '0;
          alu_b     <= '0;
          alu_ainv  <= 1'b0;
          alu_binv  <= 1'b0;
          alu_cin   <= 1'b0;
          alu_op    <= 2'b00;
        end
        ST_MUL: begin
          // Count reaches MUL_ITERS one cycle after the last add; publish then
          if (cnt_r == CNT_W'(MUL_ITERS)) begin
            state_r   <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= acc_r;
            rsp_zero  <= (acc_r == '0);
            rsp_carry <= 1'b0;
          end else begin
            acc_r    <= acc_nxt_s;
            mcand_r  <= mcand_nxt_s;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_W'(MUL_ITERS - 1)) begin
              alu_a  <= '0;
              alu_b  <= '0;
              alu_op <= 2'b00;
            end else begin
              alu_a  <= acc_nxt_s;
              alu_b  <= mcand_nxt_s;
              alu_op <= ALU_CTRL_ADD.op;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r   <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu64_op_sequencer.sv
// Directed self-checking bench for alu64_op_sequencer with a behavioural
// model of the external combinational ALU.
module tb_alu64_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [63:0] cmd_a;
  logic [63:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_err;
  logic        busy;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic        alu_ainv;
  logic        alu_binv;
  logic        alu_cin;
  logic [1:0]  alu_op;
  logic [63:0] alu_result;
  logic        alu_cout;

  int tests_run = 0;
  int tests_failed = 0;

  alu64_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ainv(alu_ainv), .alu_binv(alu_binv),
    .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // External ALU: optional inversion, then AND / OR / ADD with carry-in
  logic [63:0] ea;
  logic [63:0] eb;
  logic [64:0] sum;
  always_comb begin
    ea  = alu_ainv ? ~alu_a : alu_a;
    eb  = alu_binv ? ~alu_b : alu_b;
    sum = {1'b0, ea} + {1'b0, eb} + {64'd0, alu_cin};
    case (alu_op)
      2'b00:   alu_result = ea & eb;
      2'b01:   alu_result = ea | eb;
      default: alu_result = sum[63:0];
    endcase
    alu_cout = sum[64];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Present one command; returns after the accepting edge, sampled at the next negedge.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    check("cmd_ready_before_issue", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Count edges after acceptance until rsp_valid is seen, bounded.
  task automatic wait_rsp(input string tag, input int exp_lat);
    int cycles = 0;
    while (!rsp_valid && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_latency"}, 64'(cycles), 64'(exp_lat));
  endtask

  task automatic check_rsp(input string tag, input logic [63:0] data,
                           input logic carry, input logic zero, input logic err);
    check({tag, "_data"},  rsp_data, data);
    check({tag, "_carry"}, {63'd0, rsp_carry}, {63'd0, carry});
    check({tag, "_zero"},  {63'd0, rsp_zero},  {63'd0, zero});
    check({tag, "_err"},   {63'd0, rsp_err},   {63'd0, err});
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, {63'd0, rsp_valid}, 64'd0);
    check({tag, "_ready_rise"}, {63'd0, cmd_ready}, 64'd1);
    rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int lat, input logic [63:0] data,
                        input logic carry, input logic zero, input logic err);
    issue(op, a, b);
    wait_rsp(tag, lat);
    check_rsp(tag, data, carry, zero, err);
    finish_rsp(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_a     = 64'd0;
    cmd_b     = 64'd0;
    rsp_ready = 1'b0;
    #12;
    check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_busy",      {63'd0, busy},      64'd0);
    check("reset_rsp_data",  rsp_data,           64'd0);
    check("reset_alu_a",     alu_a,              64'd0);
    rst_n = 1'b1;

    run_op("and",  3'b000, 64'd5, 64'd2, 1, 64'd0, 1'b0, 1'b1, 1'b0);
    run_op("or",   3'b001, 64'd5, 64'd2, 1, 64'd7, 1'b0, 1'b0, 1'b0);
    run_op("add",  3'b010, 64'd5, 64'd2, 1, 64'd7, 1'b0, 1'b0, 1'b0);

    // SUB: check the ALU control lines while the operation is in flight
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 64'd5; cmd_b = 64'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("sub_alu_binv", {63'd0, alu_binv}, 64'd1);
    check("sub_alu_cin",  {63'd0, alu_cin},  64'd1);
    check("sub_alu_op",   {62'd0, alu_op},   64'd2);
    check("sub_busy",     {63'd0, busy},     64'd1);
    wait_rsp("sub_5_2", 1);
    check_rsp("sub_5_2", 64'd3, 1'b1, 1'b0, 1'b0);
    check("resp_alu_zeroed", alu_a, 64'd0);
    finish_rsp("sub_5_2");

    run_op("sub_2_5", 3'b011, 64'd2, 64'd5, 1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0);
    run_op("sub_5_5", 3'b011, 64'd5, 64'd5, 1, 64'd0, 1'b1, 1'b1, 1'b0);
    run_op("nor",     3'b100, 64'd5, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 1'b0);
    run_op("nand",    3'b101, 64'd5, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("mul_a",   3'b110, 64'h1_0000_0001, 64'd3, 65, 64'h3_0000_0003, 1'b0, 1'b0, 1'b0);
    run_op("mul_ovf", 3'b110, 64'h8000_0000_0000_0000, 64'd2, 65, 64'd0, 1'b0, 1'b1, 1'b0);
    run_op("mul_big", 3'b110, 64'd1000, 64'd12345, 65, 64'd12345000, 1'b0, 1'b0, 1'b0);

    // Reserved opcode, response held for 5 cycles while a new command is offered
    issue(3'b111, 64'd9, 64'd9);
    wait_rsp("rsvd", 0);
    check_rsp("rsvd", 64'd0, 1'b0, 1'b1, 1'b1);
    cmd_valid = 1'b1; cmd_op = 3'b010; cmd_a = 64'd1; cmd_b = 64'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, rsp_valid}, 64'd1);
      check("hold_err",   {63'd0, rsp_err},   64'd1);
      check("hold_data",  rsp_data,           64'd0);
      check("hold_ready", {63'd0, cmd_ready}, 64'd0);
    end
    cmd_valid = 1'b0;
    finish_rsp("rsvd");

    // rsp_ready high before the response appears: single-cycle completion
    rsp_ready = 1'b1;
    issue(3'b010, 64'd40, 64'd2);
    wait_rsp("pre_ready", 1);
    check("pre_ready_data", rsp_data, 64'd42);
    @(posedge clk);
    #1;
    check("pre_ready_done", {63'd0, rsp_valid}, 64'd0);
    rsp_ready = 1'b0;

    // Reset in the middle of a multiply aborts it
    issue(3'b110, 64'd7, 64'd7);
    for (int i = 0; i < 30; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid",     {63'd0, rsp_valid}, 64'd0);
    check("rst_mid_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_mid_busy",      {63'd0, busy},      64'd0);
    check("rst_mid_alu_b",     alu_b,              64'd0);
    check("rst_mid_alu_op",    {62'd0, alu_op},    64'd0);
    check("rst_mid_data",      rsp_data,           64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add_after_rst", 3'b010, 64'd1, 64'd1, 1, 64'd2, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu64_op_sequencer.md
# alu64_op_sequencer

Command-driven controller for the combinational 64-bit ALU (AND/OR/ADD core with a-invert, b-invert, carry-in). It accepts one operation per valid/ready handshake and derives the ALU control lines (aInvert, bInvert, carryIn, operation). It registers the result, carry and flags, and returns them through a valid/ready response channel. It also sequences a multi-cycle unsigned multiply by iterating the ALU's ADD path 64 times. It sits between the register-file/issue logic and the ALU instance.

## Interface
- WIDTH, 64, operand/result width; fixed at 64 to match the ALU.
- MUL_ITERS, 64, multiply iterations; must equal WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller accepts a command this cycle.
- cmd_op  in  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 NOR, 101 NAND, 110 MUL, 111 reserved.
- cmd_a, cmd_b  in  64  operands.
- rsp_valid  out  1  response held valid.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  64  result.
- rsp_carry  out  1  ALU carryOut for ADD/SUB; 0 otherwise.
- rsp_zero  out  1  rsp_data == 0.
- rsp_err  out  1  reserved opcode.
- busy  out  1  state != IDLE.
- alu_a, alu_b  out  64  ALU operands.
- alu_ainv, alu_binv, alu_cin  out  1  ALU aInvert/bInvert/carryIn.
- alu_op  out  2  ALU operation: 00 AND, 01 OR, 10 ADD.
- alu_result  in  64  ALU result, low 64 bits; bit 64 is unused.
- alu_cout  in  1  ALU carryOut.

## Operation
- States are IDLE, EXEC, MUL and RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch the opcode and operands.
  - Next state: MUL for 110, RESP with rsp_err=1 and data 0 for 111, EXEC otherwise.
- EXEC:
  - Drive the ALU from the latched operands, one cycle.
  - Register alu_result and alu_cout, then go to RESP.
- Decode (ainv, binv, cin, op):
  - AND = 0,0,0,00.
  - OR = 0,0,0,01.
  - ADD = 0,0,0,10.
  - SUB = 0,1,1,10.
  - NOR = 1,1,0,00.
  - NAND = 1,1,0,01.
- MUL (unsigned shift-add, low 64 bits of product):
  - Init: acc=0, mcand=a, mplier=b, cnt=0.
  - Each cycle, drive the ALU with acc and mcand as ADD (0,0,0,10).
  - If mplier[0]=1, acc←alu_result; otherwise acc holds.
  - Then mcand←mcand<<1, mplier←mplier>>1, cnt+1.
  - Always run exactly 64 iterations, then go to RESP.
  - Overflow is discarded; rsp_carry=0.
- RESP:
  - rsp_valid=1; all rsp_* outputs stay stable until rsp_ready.
  - On handshake, go to IDLE.
- ALU outputs are driven to all-zero in IDLE and RESP.
- No command is accepted outside IDLE.

## Timing
- Reset: state=IDLE, and every register and output is 0, except cmd_ready=1.
  - Asserting rst_n low mid-EXEC or mid-MUL aborts the operation; no response is produced.
- Command accepted at edge N. Logic ops, ADD and SUB have rsp_valid from N+2. MUL has rsp_valid from N+66 (1 setup + 64 iterations + 1). Reserved opcode has rsp_valid from N+1.
- rsp_ready high at edge M: rsp_valid drops after M, cmd_ready rises after M, and the next command is accepted no earlier than M+1.
- rsp_ready already high when rsp_valid rises: the response completes in one cycle.
- cmd_valid high in any state other than IDLE is ignored; the command is not consumed.
- The ALU is purely combinational. alu_result is sampled at the same edge the controller drives it; no extra pipeline stage.

## Structure
- Package alu64_seq_pkg:
  - opcode enum (3-bit).
  - state enum.
  - ALU_OP_AND/OR/ADD constants.
  - decode-record typedef {ainv, binv, cin, op}.
- Sub-module alu64_op_decode: combinational mapping cmd_op to the decode record, plus an illegal flag.
- FSM, operand/acc/shift registers and the counter live in the top module.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- a=5, b=2, ops AND/OR/ADD in turn -> rsp_data 0, 7, 7; rsp_carry 0; rsp_valid at N+2 each time.
- SUB with a=5, b=2 -> data 3, carry 1. SUB with a=2, b=5 -> data 0xFFFF_FFFF_FFFF_FFFD, carry 0. SUB with a=5, b=5 -> data 0, zero=1.
- NOR and NAND with a=5, b=2 -> data 0xFFFF_FFFF_FFFF_FFF8 and 0xFFFF_FFFF_FFFF_FFFF respectively.
- MUL with a=0x1_0000_0001, b=3 -> data 0x3_0000_0003 at N+66. MUL with a=2^63, b=2 -> data 0, zero=1, carry 0.
- Opcode 111 -> rsp_err=1, data 0 at N+1. Hold rsp_ready low for 5 cycles -> outputs stable and cmd_ready=0 throughout.
- Assert rst_n low at iteration 30 of a MUL -> all outputs 0, cmd_ready=1; a following ADD 1+1 returns 2.
